// File: rtl/tile_redraw_scheduler.sv
// Purpose: sequences the 5x5 tile drawer, running full 21x21 raster sweeps and servicing a FIFO of dirty tiles.
// Latency: a push into an idle scheduler reaches draw_start 2 cycles later; sweeps issue one tile per drawer latency + 1.
// Backpressure: dirty_ready drops while the FIFO is full; a push offered then is dropped and recorded in overflow.
module tile_redraw_scheduler #(
  parameter int QDEPTH  = 8,
  parameter int QAW     = 3,
  parameter int MAP_MAX = 20
) (
  input  logic           clock_50,
  input  logic           reset,
  input  logic           dirty_valid,
  input  logic [4:0]     dirty_x,
  input  logic [4:0]     dirty_y,
  output logic           dirty_ready,
  input  logic           full_refresh_req,
  output logic [4:0]     tile_x,
  output logic [4:0]     tile_y,
  output logic           draw_start,
  input  logic           draw_done,
  output logic           sweep_active,
  output logic [QAW:0]   queue_count,
  output logic           bad_coord,
  output logic           overflow
);

  localparam logic [4:0]   L_MAX  = 5'(MAP_MAX);
  localparam logic [QAW:0] L_FULL = (QAW+1)'(QDEPTH);

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
  } tile_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SW_ISSUE,
    S_SW_WAIT,
    S_Q_ISSUE,
    S_Q_WAIT
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_post_rst;
  tile_t          r_tile;
  logic           r_sweep_req;
  logic           r_sweep_active;
  tile_t          r_mem [QDEPTH];
  logic [QAW-1:0] r_wr_ptr;
  logic [QAW-1:0] r_rd_ptr;
  logic [QAW:0]   r_count;
  logic           r_bad;
  logic           r_ovf;

  logic           w_draw_start;
  logic           w_sweep_start;
  logic           w_sweep_adv;
  logic           w_sweep_end;
  logic           w_load_q;
  logic           w_pop;
  logic           w_last;
  logic           w_full;
  logic           w_in_range;
  logic           w_push_acc;
  logic           w_store;
  tile_t          w_in_tile;

  assign w_last     = (r_tile.x == L_MAX) && (r_tile.y == L_MAX);
  assign w_full     = (r_count == L_FULL);
  assign w_in_range = (dirty_x <= L_MAX) && (dirty_y <= L_MAX);
  assign w_push_acc = dirty_valid && !w_full;
  assign w_store    = w_push_acc && w_in_range;
  assign w_in_tile  = '{x: dirty_x, y: dirty_y};

  // State register; reset lands in SW_ISSUE so a sweep begins on its own.
  always_ff @(posedge clock_50) begin
    if (reset) r_state <= S_SW_ISSUE;
    else       r_state <= w_next;
  end

  // The first cycle after reset keeps draw_start low so every output shows its reset value.
  always_ff @(posedge clock_50) begin
    if (reset) r_post_rst <= 1'b1;
    else       r_post_rst <= 1'b0;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_next        = r_state;
    w_draw_start  = 1'b0;
    w_sweep_start = 1'b0;
    w_sweep_adv   = 1'b0;
    w_sweep_end   = 1'b0;
    w_load_q      = 1'b0;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_sweep_req) begin
          w_next        = S_SW_ISSUE;
          w_sweep_start = 1'b1;
        end else if (r_count != '0) begin
          w_next   = S_Q_ISSUE;
          w_load_q = 1'b1;
        end
      end
      S_SW_ISSUE: begin
        if (!r_post_rst) begin
          w_draw_start = 1'b1;
          w_next       = S_SW_WAIT;
        end
      end
      S_SW_WAIT: begin
        if (draw_done) begin
          if (r_sweep_req) begin
            w_next        = S_SW_ISSUE;
            w_sweep_start = 1'b1;
          end else if (w_last) begin
            w_next      = S_IDLE;
            w_sweep_end = 1'b1;
          end else begin
            w_next      = S_SW_ISSUE;
            w_sweep_adv = 1'b1;
          end
        end
      end
      S_Q_ISSUE: begin
        w_draw_start = 1'b1;
        w_pop        = 1'b1;
        w_next       = S_Q_WAIT;
      end
      S_Q_WAIT: begin
        if (draw_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Tile coordinate: raster counter during sweeps, FIFO head (captured one cycle before issue) for queued tiles.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_tile <= '0;
    end else if (w_sweep_start || w_sweep_end) begin
      r_tile <= '0;
    end else if (w_sweep_adv) begin
      if (r_tile.x == L_MAX) begin
        r_tile.x <= '0;
        r_tile.y <= r_tile.y + 5'd1;
      end else begin
        r_tile.x <= r_tile.x + 5'd1;
      end
    end else if (w_load_q) begin
      r_tile <= r_mem[r_rd_ptr];
    end
  end

  // Sweep request is latched until a sweep actually starts; sweep_active rises with the request.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_sweep_req    <= 1'b0;
      r_sweep_active <= 1'b1;
    end else begin
      r_sweep_req <= w_sweep_start ? 1'b0 : (r_sweep_req || full_refresh_req);
      if (full_refresh_req)  r_sweep_active <= 1'b1;
      else if (w_sweep_end)  r_sweep_active <= 1'b0;
    end
  end

  // FIFO storage; a flush moves the read pointer onto the write slot so a same-cycle push survives.
  always_ff @(posedge clock_50) begin
    if (w_store) r_mem[r_wr_ptr] <= w_in_tile;
  end

  // FIFO pointers and occupancy, with the flush taken when a sweep starts.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_sweep_start) begin
      r_rd_ptr <= r_wr_ptr;
      r_wr_ptr <= r_wr_ptr + QAW'(w_store);
      r_count  <= (QAW+1)'(w_store);
    end else begin
      r_wr_ptr <= r_wr_ptr + QAW'(w_store);
      r_rd_ptr <= r_rd_ptr + QAW'(w_pop);
      r_count  <= r_count + (QAW+1)'(w_store) - (QAW+1)'(w_pop);
    end
  end

  // Sticky error flags for out-of-range pushes and pushes offered while full.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_bad <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push_acc && !w_in_range) r_bad <= 1'b1;
      if (dirty_valid && w_full)     r_ovf <= 1'b1;
    end
  end

  assign dirty_ready  = !w_full;
  assign tile_x       = r_tile.x;
  assign tile_y       = r_tile.y;
  assign draw_start   = w_draw_start;
  assign sweep_active = r_sweep_active;
  assign queue_count  = r_count;
  assign bad_coord    = r_bad;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_tile_redraw_scheduler.sv
// Bench for tile_redraw_scheduler: a drawer model answers each draw_start and checks
// every drawn tile against an ordered list of expected tiles built from the sweep/queue rules.
module tb_tile_redraw_scheduler;
  localparam int QDEPTH  = 8;
  localparam int QAW     = 3;
  localparam int MAP_MAX = 20;

  logic           clock_50 = 1'b0;
  logic           reset;
  logic           dirty_valid;
  logic [4:0]     dirty_x;
  logic [4:0]     dirty_y;
  logic           dirty_ready;
  logic           full_refresh_req;
  logic [4:0]     tile_x;
  logic [4:0]     tile_y;
  logic           draw_start;
  logic           draw_done;
  logic           sweep_active;
  logic [QAW:0]   queue_count;
  logic           bad_coord;
  logic           overflow;

  tile_redraw_scheduler #(.QDEPTH(QDEPTH), .QAW(QAW), .MAP_MAX(MAP_MAX)) dut (
    .clock_50         (clock_50),
    .reset            (reset),
    .dirty_valid      (dirty_valid),
    .dirty_x          (dirty_x),
    .dirty_y          (dirty_y),
    .dirty_ready      (dirty_ready),
    .full_refresh_req (full_refresh_req),
    .tile_x           (tile_x),
    .tile_y           (tile_y),
    .draw_start       (draw_start),
    .draw_done        (draw_done),
    .sweep_active     (sweep_active),
    .queue_count      (queue_count),
    .bad_coord        (bad_coord),
    .overflow         (overflow)
  );

  always #10 clock_50 = ~clock_50;

  int         total = 0;
  int         bad = 0;
  logic [9:0] exp_q[$];       // expected draw order, {x,y}; appended by the stimulus
  int         rd_idx = 0;     // next expectation, advanced by the drawer
  int         rst_resume = 0; // where expectations restart after a reset
  int         drv_lat = 25;   // 0 selects a random latency per tile
  bit         drv_stall = 1'b0;
  bit         busy = 1'b0;
  bit         late_pending = 1'b0;
  int         n_starts = 0;
  logic [9:0] last_start = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, want);
    end
  endtask

  function automatic logic [4:0] rnd_coord();
    return 5'($urandom_range(0, MAP_MAX));
  endfunction

  task automatic add_sweep();
    for (int y = 0; y <= MAP_MAX; y++)
      for (int x = 0; x <= MAP_MAX; x++)
        exp_q.push_back({5'(x), 5'(y)});
  endtask

  task automatic tick();
    @(negedge clock_50);
  endtask

  task automatic push(input logic [4:0] x, input logic [4:0] y);
    dirty_valid = 1'b1;
    dirty_x = x;
    dirty_y = y;
    tick();
    dirty_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (((exp_q.size() > rd_idx) || busy) && n < budget) begin
      tick();
      n++;
    end
    check(tag, (exp_q.size() - rd_idx) + int'(busy), 0);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_tile"},    {tile_x, tile_y}, 0);
    check({pfx, "_start"},   draw_start, 0);
    check({pfx, "_sweep"},   sweep_active, 1);
    check({pfx, "_qcount"},  queue_count, 0);
    check({pfx, "_bad"},     bad_coord, 0);
    check({pfx, "_ovf"},     overflow, 0);
    check({pfx, "_ready"},   dirty_ready, 1);
  endtask

  // Drawer model: samples just after the falling edge, answers draw_start after its latency,
  // and on reset abandons the tile but still delivers one late draw_done.
  initial begin : drawer
    int         cnt;
    logic [9:0] cur;
    cnt = 0;
    cur = '0;
    draw_done = 1'b0;
    forever begin
      @(negedge clock_50);
      #1;
      draw_done = 1'b0;
      if (reset) begin
        if (busy) late_pending = 1'b1;
        busy = 1'b0;
        rd_idx = rst_resume;
      end else begin
        if (late_pending) begin
          draw_done = 1'b1;
          late_pending = 1'b0;
        end else if (busy && !drv_stall) begin
          if (cnt <= 1) begin
            check("tile_stable", {tile_x, tile_y}, cur);
            draw_done = 1'b1;
            busy = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (draw_start) begin
          cur = {tile_x, tile_y};
          last_start = cur;
          n_starts++;
          check("start_drawer_free", busy, 0);
          check("start_expected", exp_q.size() > rd_idx, 1);
          if (exp_q.size() > rd_idx) begin
            check("draw_order", cur, exp_q[rd_idx]);
            rd_idx++;
          end
          busy = 1'b1;
          cnt = (drv_lat == 0) ? int'($urandom_range(1, 5)) : drv_lat;
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [4:0] x;
    logic [4:0] y;
    int         base;
    int         n;
    int         n_pushed;
    bit         ovf_exp;

    reset = 1'b1;
    dirty_valid = 1'b0;
    dirty_x = '0;
    dirty_y = '0;
    full_refresh_req = 1'b0;

    // Reset, then the automatic power-on sweep with a 25-cycle drawer.
    repeat (3) tick();
    check_reset_values("rst1");
    add_sweep();
    base = n_starts;
    reset = 1'b0;
    wait_idle(441 * 27 + 200, "sweep1_drain");
    check("sweep1_tiles", n_starts - base, 441);
    tick();
    check("sweep1_inactive", sweep_active, 0);
    repeat (3) begin
      tick();
      check("idle_no_start", draw_start, 0);
    end

    // Single dirty tile: draw_start two cycles after the push.
    drv_lat = 4;
    exp_q.push_back({5'd10, 5'd8});
    push(5'd10, 5'd8);
    check("q1_count_1", queue_count, 1);
    check("q1_not_yet", draw_start, 0);
    tick();
    check("q1_start", draw_start, 1);
    check("q1_tile", {tile_x, tile_y}, {5'd10, 5'd8});
    tick();
    check("q1_count_0", queue_count, 0);
    wait_idle(100, "q1_drain");

    // Fill the FIFO behind a stalled tile: 8 accepted, the 9th overflows.
    drv_lat = 3;
    drv_stall = 1'b1;
    base = n_starts;
    x = rnd_coord();
    y = rnd_coord();
    exp_q.push_back({x, y});
    push(x, y);
    tick();
    tick();
    check("fill_pre_ovf", overflow, 0);
    for (int i = 0; i < QDEPTH + 1; i++) begin
      x = rnd_coord();
      y = rnd_coord();
      check("fill_ready", dirty_ready, i < QDEPTH);
      if (i < QDEPTH) exp_q.push_back({x, y});
      push(x, y);
    end
    check("fill_ovf", overflow, 1);
    check("fill_count", queue_count, QDEPTH);
    check("fill_ready_low", dirty_ready, 0);
    drv_stall = 1'b0;
    wait_idle(400, "fill_drain");
    check("fill_tiles", n_starts - base, QDEPTH + 1);

    // Out-of-range push: flagged, not stored, never drawn.
    x = 5'($urandom_range(21, 31));
    check("bad_pre", bad_coord, 0);
    push(x, 5'd3);
    check("bad_set", bad_coord, 1);
    check("bad_count", queue_count, 0);
    repeat (4) begin
      tick();
      check("bad_no_start", draw_start, 0);
    end

    // Refresh during a queued tile: tile finishes, FIFO flushed, sweep, then a push made mid-sweep.
    drv_lat = 12;
    x = rnd_coord();
    y = rnd_coord();
    exp_q.push_back({x, y});
    push(x, y);
    tick();
    tick();
    full_refresh_req = 1'b1;
    tick();
    full_refresh_req = 1'b0;
    check("refresh_active", sweep_active, 1);
    add_sweep();
    push(rnd_coord(), rnd_coord());
    check("junk_count", queue_count, 1);
    base = n_starts;
    n = 0;
    while (n_starts == base && n < 200) begin
      tick();
      n++;
    end
    check("sweep2_started", n_starts > base, 1);
    check("sweep2_flushed", queue_count, 0);
    repeat (3) tick();
    exp_q.push_back({5'd5, 5'd5});
    push(5'd5, 5'd5);
    check("sweep2_held", queue_count, 1);
    wait_idle(441 * 14 + 300, "sweep2_drain");
    check("sweep2_tiles", n_starts - base, 442);
    tick();
    check("sweep2_inactive", sweep_active, 0);

    // Reset in the middle of tile (7,4): reset values, late draw_done ignored, sweep from (0,0).
    drv_lat = 6;
    full_refresh_req = 1'b1;
    tick();
    full_refresh_req = 1'b0;
    add_sweep();
    n = 0;
    while (last_start != {5'd7, 5'd4} && n < 3000) begin
      tick();
      n++;
    end
    check("found_7_4", last_start, {5'd7, 5'd4});
    tick();
    tick();
    rst_resume = exp_q.size();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("rst2");
    add_sweep();
    base = n_starts;
    wait_idle(441 * 8 + 300, "sweep3_drain");
    check("sweep3_tiles", n_starts - base, 441);
    tick();
    check("sweep3_inactive", sweep_active, 0);

    // Random traffic against the occupancy model, including offers while full.
    drv_lat = 0;
    base = n_starts;
    n_pushed = 0;
    ovf_exp = 1'b0;
    for (int c = 0; c < 400; c++) begin
      n = n_pushed - (n_starts - base);
      check("rnd_count", queue_count, n);
      check("rnd_ready", dirty_ready, n < QDEPTH);
      dirty_valid = 1'b0;
      if (n < QDEPTH && $urandom_range(0, 2) == 0) begin
        x = rnd_coord();
        y = rnd_coord();
        exp_q.push_back({x, y});
        n_pushed++;
        dirty_valid = 1'b1;
        dirty_x = x;
        dirty_y = y;
      end else if (n == QDEPTH && $urandom_range(0, 3) == 0) begin
        ovf_exp = 1'b1;
        dirty_valid = 1'b1;
        dirty_x = rnd_coord();
        dirty_y = rnd_coord();
      end
      tick();
    end
    dirty_valid = 1'b0;
    wait_idle(300, "rnd_drain");
    check("rnd_ovf", overflow, ovf_exp);
    check("rnd_bad", bad_coord, 0);
    check("rnd_tiles", n_starts - base, n_pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
